// File: rtl/bck_lp_dtct_if.sv
// Fetch-group, branch-resolution and registered-output signals of the backward-loop detector.
// master drives fetch/resolution and observes the outputs; slave is the detector.
interface bck_lp_dtct_if;
   logic [63:0] inst_in;
   logic [63:0] pc_in;
   logic [3:0]  inst_vld_in;
   logic        stll_in;
   logic        mis_pred_in;
   logic        br_rslv_vld_in;
   logic [15:0] br_rslv_pc_in;
   logic        br_rslv_tkn_in;
   logic        br_rslv_bck_in;
   logic [3:0]  bck_lp_bus_out;
   logic [63:0] pc_out;
   logic [63:0] inst_out;
   logic [3:0]  vld_out;

   modport master (
      output inst_in, pc_in, inst_vld_in, stll_in, mis_pred_in,
             br_rslv_vld_in, br_rslv_pc_in, br_rslv_tkn_in, br_rslv_bck_in,
      input  bck_lp_bus_out, pc_out, inst_out, vld_out
   );

   modport slave (
      input  inst_in, pc_in, inst_vld_in, stll_in, mis_pred_in,
             br_rslv_vld_in, br_rslv_pc_in, br_rslv_tkn_in, br_rslv_bck_in,
      output bck_lp_bus_out, pc_out, inst_out, vld_out
   );
endinterface

// File: rtl/bck_lp_dtct.sv
// Flags the oldest loop-like backward branch of a 4-wide fetch group; 1-cycle latency.
// stll_in holds every output register, mis_pred_in clears flag/valids and wins over the stall.
module bck_lp_dtct #(
   parameter int          DEPTH  = 4,
   parameter int          THRESH = 2,
   parameter logic [3:0]  BR_OPC = 4'hC
) (
   input logic          clk,
   input logic          rst,
   bck_lp_dtct_if.slave bus
);
   localparam int         PW  = $clog2(DEPTH);
   localparam logic [1:0] THR = 2'(THRESH);

   logic [DEPTH-1:0] tbl_vld;
   logic [15:0]      tbl_pc  [DEPTH];
   logic [1:0]       tbl_cnt [DEPTH];
   logic [PW-1:0]    ptr;

   // Slot arrays are indexed by age: index 0 is the oldest instruction.
   logic [15:0] slot_inst [4];
   logic [15:0] slot_pc   [4];
   logic [3:0]  slot_vld;
   logic [3:0]  loop_like;
   logic [3:0]  flag_nxt;
   logic [3:0]  vld_nxt;
   logic          rs_hit;
   logic [PW-1:0] rs_idx;

   always_comb begin
      for (int s = 0; s < 4; s++) begin
         slot_inst[s] = bus.inst_in[63-16*s -: 16];
         slot_pc[s]   = bus.pc_in[63-16*s -: 16];
         slot_vld[s]  = bus.inst_vld_in[3-s];
      end
   end

   always_comb begin
      loop_like = '0;
      for (int s = 0; s < 4; s++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (slot_vld[s] && (slot_inst[s][15:12] == BR_OPC) && slot_inst[s][7] &&
                tbl_vld[e] && (tbl_pc[e] == slot_pc[s]) && (tbl_cnt[e] >= THR))
               loop_like[s] = 1'b1;
         end
      end
   end

   // Walk youngest to oldest so the oldest loop-like slot has the final say.
   always_comb begin
      flag_nxt = '0;
      vld_nxt  = bus.inst_vld_in;
      for (int s = 3; s >= 0; s--) begin
         if (loop_like[s]) begin
            flag_nxt = 4'b1000 >> s;
            vld_nxt  = bus.inst_vld_in & ~(4'b0111 >> s);
         end
      end
   end

   always_comb begin
      rs_hit = 1'b0;
      rs_idx = '0;
      for (int e = DEPTH-1; e >= 0; e--) begin
         if (tbl_vld[e] && (tbl_pc[e] == bus.br_rslv_pc_in)) begin
            rs_hit = 1'b1;
            rs_idx = PW'(e);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr     <= '0;
         tbl_vld <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            tbl_pc[e]  <= '0;
            tbl_cnt[e] <= '0;
         end
      end else if (bus.br_rslv_vld_in && bus.br_rslv_bck_in) begin
         if (rs_hit) begin
            if (!bus.br_rslv_tkn_in)
               tbl_cnt[rs_idx] <= 2'd0;
            else if (tbl_cnt[rs_idx] != 2'd3)
               tbl_cnt[rs_idx] <= tbl_cnt[rs_idx] + 2'd1;
         end else if (bus.br_rslv_tkn_in) begin
            tbl_vld[ptr] <= 1'b1;
            tbl_pc[ptr]  <= bus.br_rslv_pc_in;
            tbl_cnt[ptr] <= 2'd1;
            ptr          <= ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.bck_lp_bus_out <= '0;
         bus.vld_out        <= '0;
         bus.pc_out         <= '0;
         bus.inst_out       <= '0;
      end else if (bus.mis_pred_in) begin
         bus.bck_lp_bus_out <= '0;
         bus.vld_out        <= '0;
         bus.pc_out         <= bus.pc_in;
         bus.inst_out       <= bus.inst_in;
      end else if (!bus.stll_in) begin
         bus.bck_lp_bus_out <= flag_nxt;
         bus.vld_out        <= vld_nxt;
         bus.pc_out         <= bus.pc_in;
         bus.inst_out       <= bus.inst_in;
      end
   end
endmodule

// File: tb/tb_bck_lp_dtct.sv
// Bench for bck_lp_dtct: queue-based reference model checked every cycle, plus literal anchors.
module tb_bck_lp_dtct;
   localparam int         DEPTH  = 4;
   localparam int         THRESH = 2;
   localparam logic [3:0] BR_OPC = 4'hC;

   logic clk;
   logic rst;
   int   errs  = 0;
   int   total = 0;

   bck_lp_dtct_if ifc();

   bck_lp_dtct #(.DEPTH(DEPTH), .THRESH(THRESH), .BR_OPC(BR_OPC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference table: allocation order equals eviction order, so a bounded FIFO suffices.
   logic [15:0] q_pc[$];
   int          q_cnt[$];
   logic [3:0]  e_bus, e_vld;
   logic [63:0] e_pc, e_inst;

   function automatic int mfind(input logic [15:0] p);
      mfind = -1;
      foreach (q_pc[i]) if (q_pc[i] == p) mfind = i;
   endfunction

   always @(posedge clk or negedge rst) begin : model
      int          fl, k;
      logic [15:0] ins, p;
      logic [3:0]  nb, nv;
      if (!rst) begin
         q_pc.delete();
         q_cnt.delete();
         e_bus = '0; e_vld = '0; e_pc = '0; e_inst = '0;
      end else begin
         fl = -1;
         for (int s = 0; s < 4; s++) begin
            ins = ifc.inst_in[16*(3-s) +: 16];
            p   = ifc.pc_in[16*(3-s) +: 16];
            k   = mfind(p);
            if (fl < 0 && ifc.inst_vld_in[3-s] && ins[15:12] == BR_OPC && ins[7] &&
                k >= 0 && q_cnt[k] >= THRESH)
               fl = s;
         end
         nb = '0;
         nv = ifc.inst_vld_in;
         if (fl >= 0) begin
            nb[3-fl] = 1'b1;
            for (int s = fl + 1; s < 4; s++) nv[3-s] = 1'b0;
         end
         if (ifc.mis_pred_in) begin
            e_bus = '0; e_vld = '0; e_pc = ifc.pc_in; e_inst = ifc.inst_in;
         end else if (!ifc.stll_in) begin
            e_bus = nb; e_vld = nv; e_pc = ifc.pc_in; e_inst = ifc.inst_in;
         end
         if (ifc.br_rslv_vld_in && ifc.br_rslv_bck_in) begin
            k = mfind(ifc.br_rslv_pc_in);
            if (k >= 0)
               q_cnt[k] = ifc.br_rslv_tkn_in ? ((q_cnt[k] < 3) ? q_cnt[k] + 1 : 3) : 0;
            else if (ifc.br_rslv_tkn_in) begin
               q_pc.push_back(ifc.br_rslv_pc_in);
               q_cnt.push_back(1);
               if (q_pc.size() > DEPTH) begin
                  void'(q_pc.pop_front());
                  void'(q_cnt.pop_front());
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_bus",  {60'b0, ifc.bck_lp_bus_out}, {60'b0, e_bus});
      chk("cyc_vld",  {60'b0, ifc.vld_out}, {60'b0, e_vld});
      chk("cyc_pc",   ifc.pc_out, e_pc);
      chk("cyc_inst", ifc.inst_out, e_inst);
   end

   task automatic lit(input string nm, input logic [3:0] xb, input logic [3:0] xv);
      chk({nm, "_model_bus"}, {60'b0, e_bus}, {60'b0, xb});
      chk({nm, "_bus"}, {60'b0, ifc.bck_lp_bus_out}, {60'b0, xb});
      chk({nm, "_vld"}, {60'b0, ifc.vld_out}, {60'b0, xv});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic fetch(input logic [63:0] ins, input logic [63:0] pcs, input logic [3:0] v);
      ifc.inst_in     = ins;
      ifc.pc_in       = pcs;
      ifc.inst_vld_in = v;
   endtask

   task automatic train(input logic [15:0] p, input logic tkn, input logic bck);
      ifc.br_rslv_vld_in = 1'b1;
      ifc.br_rslv_pc_in  = p;
      ifc.br_rslv_tkn_in = tkn;
      ifc.br_rslv_bck_in = bck;
      tick();
      ifc.br_rslv_vld_in = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      ifc.stll_in = 1'b0; ifc.mis_pred_in = 1'b0;
      ifc.br_rslv_vld_in = 1'b0; ifc.br_rslv_pc_in = '0;
      ifc.br_rslv_tkn_in = 1'b0; ifc.br_rslv_bck_in = 1'b0;
      fetch({16'hC0F8, 48'h0}, {16'h0010, 48'h0}, 4'b1000);
      repeat (3) tick();
      lit("rst", 4'b0000, 4'b0000);
      chk("rst_pc", ifc.pc_out, 64'h0);
      chk("rst_inst", ifc.inst_out, 64'h0);
      rst = 1'b1;
      tick();
      lit("empty_tbl", 4'b0000, 4'b1000);
      chk("first_pc", ifc.pc_out, {16'h0010, 48'h0});

      train(16'h0010, 1'b1, 1'b1);
      train(16'h0010, 1'b1, 1'b1);
      fetch({16'h0000, 16'h0000, 16'hC0F8, 16'h0000},
            {16'h000C, 16'h000E, 16'h0010, 16'h0012}, 4'b1111);
      tick();
      lit("thresh", 4'b0010, 4'b1110);

      repeat (3) train(16'h0020, 1'b1, 1'b1);
      repeat (3) train(16'h0031, 1'b1, 1'b1);
      fetch({16'h1234, 16'hC0F0, 16'hC07F, 16'hC0FE},
            {16'h001E, 16'h0020, 16'h0030, 16'h0031}, 4'b1111);
      tick();
      lit("prio", 4'b0100, 4'b1100);
      fetch({16'h1234, 16'hC0F0, 16'hC07F, 16'hC0FE},
            {16'h001E, 16'h0020, 16'h0030, 16'h0031}, 4'b1011);
      tick();
      lit("prio_s3", 4'b0001, 4'b1011);

      train(16'h0010, 1'b0, 1'b1);
      fetch({16'hC0F8, 48'h0}, {16'h0010, 48'h0}, 4'b1000);
      tick();
      lit("exit", 4'b0000, 4'b1000);

      train(16'h0040, 1'b1, 1'b1);
      train(16'h0050, 1'b1, 1'b1);
      train(16'h0060, 1'b1, 1'b1);
      train(16'h0070, 1'b1, 1'b1);
      train(16'h0080, 1'b1, 1'b1);
      train(16'h0040, 1'b1, 1'b1);
      fetch({16'hC0F8, 48'h0}, {16'h0040, 48'h0}, 4'b1000);
      tick();
      lit("evict", 4'b0000, 4'b1000);
      train(16'h0040, 1'b1, 1'b0);
      tick();
      lit("no_bck", 4'b0000, 4'b1000);

      train(16'h0080, 1'b1, 1'b1);
      fetch({16'hC0F8, 16'h1111, 16'h2222, 16'h3333},
            {16'h0080, 16'h0082, 16'h0084, 16'h0086}, 4'b1111);
      tick();
      lit("wrap_hit", 4'b1000, 4'b1000);

      ifc.stll_in = 1'b1;
      fetch(64'h0, {16'hAAAA, 16'hAAAC, 16'hAAAE, 16'hAAB0}, 4'b0101);
      for (int i = 0; i < 3; i++) begin
         tick();
         lit("stall", 4'b1000, 4'b1000);
         chk("stall_pc", {48'h0, ifc.pc_out[63:48]}, 64'h0080);
      end
      ifc.mis_pred_in = 1'b1;
      tick();
      lit("flush", 4'b0000, 4'b0000);
      chk("flush_pc", {48'h0, ifc.pc_out[63:48]}, 64'hAAAA);
      ifc.mis_pred_in = 1'b0;
      ifc.stll_in = 1'b0;

      fetch({4{16'hC0F8}}, {4{16'h0080}}, 4'b0000);
      tick();
      lit("no_valid", 4'b0000, 4'b0000);

      train(16'h0090, 1'b1, 1'b1);
      fetch({16'hC0F8, 48'h0}, {16'h0090, 48'h0}, 4'b1000);
      train(16'h0090, 1'b1, 1'b1);
      lit("same_cyc", 4'b0000, 4'b1000);
      tick();
      lit("after_upd", 4'b1000, 4'b1000);

      #1 rst = 1'b0;
      #1;
      lit("arst", 4'b0000, 4'b0000);
      chk("arst_pc", ifc.pc_out, 64'h0);
      tick();
      rst = 1'b1;
      tick();
      lit("post_rst", 4'b0000, 4'b1000);
      chk("post_rst_pc", ifc.pc_out, {16'h0090, 48'h0});

      tick();
      $display("Result: errors=%0d of %0d checks", errs, total);
      $finish;
   end
endmodule
